// File: rtl/video_bg_shifter.sv
// Background pixel stage: tile latches, 16-bit pattern and 8-bit attribute shifters, fine-X pixel select.
// Optional VIDEO_BG_FINE_X_LATCH_EN: fine X is captured at each tile reload instead of being used live.
module video_bg_shifter (
  input  logic       I_clock,
  input  logic       I_reset,
  input  logic       I_dot_clk,
  input  logic [7:0] I_data,
  input  logic       I_latch_we,
  input  logic [1:0] I_latch_sel,
  input  logic       I_coarse_x1,
  input  logic       I_coarse_y1,
  input  logic       I_shift_en,
  input  logic       I_reload,
  input  logic [2:0] I_fine_x,
  output logic [7:0] O_tile_index,
  output logic [3:0] O_bg_color
);

  function automatic logic [1:0] attr_quadrant(input logic [7:0] data, input logic y1, input logic x1);
    logic [1:0] q;
    case ({y1, x1})
      2'b00:   q = data[1:0];
      2'b01:   q = data[3:2];
      2'b10:   q = data[5:4];
      2'b11:   q = data[7:6];
      default: q = 2'b00;
    endcase
    return q;
  endfunction

  // For a 3-bit fx, 15 - fx == {1'b1, ~fx} and 7 - fx == ~fx.
  function automatic logic [3:0] pixel_sel(input logic [15:0] pat_lo, input logic [15:0] pat_hi,
                                           input logic [7:0] attr_lo, input logic [7:0] attr_hi,
                                           input logic [2:0] fx);
    return {attr_hi[~fx], attr_lo[~fx], pat_hi[{1'b1, ~fx}], pat_lo[{1'b1, ~fx}]};
  endfunction

  logic [7:0]  nt_latch_r, nt_latch_s;
  logic [1:0]  attr_latch_r, attr_latch_s;
  logic [7:0]  pat_lo_latch_r, pat_lo_latch_s;
  logic [7:0]  pat_hi_latch_r, pat_hi_latch_s;
  logic [15:0] pat_lo_sh_r, pat_lo_sh_s;
  logic [15:0] pat_hi_sh_r, pat_hi_sh_s;
  logic [7:0]  attr_lo_sh_r, attr_lo_sh_s;
  logic [7:0]  attr_hi_sh_r, attr_hi_sh_s;
  logic        attr_bit_lo_r, attr_bit_lo_s;
  logic        attr_bit_hi_r, attr_bit_hi_s;
  logic [3:0]  bg_color_r, bg_color_s;
  logic [2:0]  fine_sel_s;

`ifdef VIDEO_BG_FINE_X_LATCH_EN
  logic [2:0] fine_x_r, fine_x_s;

  // Fine X capture at tile reload so mid-tile scroll writes cannot tear a tile
  always_comb begin
    fine_x_s = fine_x_r;
    if (I_dot_clk && I_reload) begin
      fine_x_s = I_fine_x;
    end else begin
      fine_x_s = fine_x_r;
    end
  end

  // Fine X register
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      fine_x_r <= 3'd0;
    end else begin
      fine_x_r <= fine_x_s;
    end
  end

  assign fine_sel_s = fine_x_s;
`else
  assign fine_sel_s = I_fine_x;
`endif

  // Fetch latches: capture the memory byte into the selected latch
  always_comb begin
    nt_latch_s     = nt_latch_r;
    attr_latch_s   = attr_latch_r;
    pat_lo_latch_s = pat_lo_latch_r;
    pat_hi_latch_s = pat_hi_latch_r;
    if (I_dot_clk && I_latch_we) begin
      case (I_latch_sel)
        2'd0:    nt_latch_s     = I_data;
        2'd1:    attr_latch_s   = attr_quadrant(I_data, I_coarse_y1, I_coarse_x1);
        2'd2:    pat_lo_latch_s = I_data;
        2'd3:    pat_hi_latch_s = I_data;
        default: nt_latch_s     = nt_latch_r;
      endcase
    end else begin
      nt_latch_s = nt_latch_r;
    end
  end

  // Shifters: shift first, then a reload overwrites the low pattern byte with the pre-write latch
  always_comb begin
    pat_lo_sh_s   = pat_lo_sh_r;
    pat_hi_sh_s   = pat_hi_sh_r;
    attr_lo_sh_s  = attr_lo_sh_r;
    attr_hi_sh_s  = attr_hi_sh_r;
    attr_bit_lo_s = attr_bit_lo_r;
    attr_bit_hi_s = attr_bit_hi_r;
    if (I_dot_clk) begin
      if (I_shift_en) begin
        pat_lo_sh_s  = {pat_lo_sh_r[14:0], 1'b0};
        pat_hi_sh_s  = {pat_hi_sh_r[14:0], 1'b0};
        attr_lo_sh_s = {attr_lo_sh_r[6:0], attr_bit_lo_r};
        attr_hi_sh_s = {attr_hi_sh_r[6:0], attr_bit_hi_r};
      end else begin
        pat_lo_sh_s  = pat_lo_sh_r;
        pat_hi_sh_s  = pat_hi_sh_r;
        attr_lo_sh_s = attr_lo_sh_r;
        attr_hi_sh_s = attr_hi_sh_r;
      end
      if (I_reload) begin
        pat_lo_sh_s   = {pat_lo_sh_s[15:8], pat_lo_latch_r};
        pat_hi_sh_s   = {pat_hi_sh_s[15:8], pat_hi_latch_r};
        attr_bit_lo_s = attr_latch_r[0];
        attr_bit_hi_s = attr_latch_r[1];
      end else begin
        attr_bit_lo_s = attr_bit_lo_r;
        attr_bit_hi_s = attr_bit_hi_r;
      end
    end else begin
      attr_bit_lo_s = attr_bit_lo_r;
      attr_bit_hi_s = attr_bit_hi_r;
    end
  end

  // Pixel select from the post-update shifter contents; held between dot enables
  always_comb begin
    bg_color_s = bg_color_r;
    if (I_dot_clk) begin
      bg_color_s = pixel_sel(pat_lo_sh_s, pat_hi_sh_s, attr_lo_sh_s, attr_hi_sh_s, fine_sel_s);
    end else begin
      bg_color_s = bg_color_r;
    end
  end

  // State registers
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      nt_latch_r     <= 8'h00;
      attr_latch_r   <= 2'b00;
      pat_lo_latch_r <= 8'h00;
      pat_hi_latch_r <= 8'h00;
      pat_lo_sh_r    <= 16'h0000;
      pat_hi_sh_r    <= 16'h0000;
      attr_lo_sh_r   <= 8'h00;
      attr_hi_sh_r   <= 8'h00;
      attr_bit_lo_r  <= 1'b0;
      attr_bit_hi_r  <= 1'b0;
      bg_color_r     <= 4'h0;
    end else begin
      nt_latch_r     <= nt_latch_s;
      attr_latch_r   <= attr_latch_s;
      pat_lo_latch_r <= pat_lo_latch_s;
      pat_hi_latch_r <= pat_hi_latch_s;
      pat_lo_sh_r    <= pat_lo_sh_s;
      pat_hi_sh_r    <= pat_hi_sh_s;
      attr_lo_sh_r   <= attr_lo_sh_s;
      attr_hi_sh_r   <= attr_hi_sh_s;
      attr_bit_lo_r  <= attr_bit_lo_s;
      attr_bit_hi_r  <= attr_bit_hi_s;
      bg_color_r     <= bg_color_s;
    end
  end

  assign O_tile_index = nt_latch_r;
  assign O_bg_color   = bg_color_r;

endmodule

// File: tb/tb_video_bg_shifter.sv
// Scoreboard bench for video_bg_shifter: stimulus pushes expected outputs, a monitor pops and compares.
module tb_video_bg_shifter;

  logic       I_clock     = 1'b0;
  logic       I_reset     = 1'b0;
  logic       I_dot_clk   = 1'b0;
  logic [7:0] I_data      = 8'h00;
  logic       I_latch_we  = 1'b0;
  logic [1:0] I_latch_sel = 2'd0;
  logic       I_coarse_x1 = 1'b0;
  logic       I_coarse_y1 = 1'b0;
  logic       I_shift_en  = 1'b0;
  logic       I_reload    = 1'b0;
  logic [2:0] I_fine_x    = 3'd0;
  logic [7:0] O_tile_index;
  logic [3:0] O_bg_color;

  video_bg_shifter dut (
    .I_clock(I_clock), .I_reset(I_reset), .I_dot_clk(I_dot_clk), .I_data(I_data),
    .I_latch_we(I_latch_we), .I_latch_sel(I_latch_sel), .I_coarse_x1(I_coarse_x1),
    .I_coarse_y1(I_coarse_y1), .I_shift_en(I_shift_en), .I_reload(I_reload),
    .I_fine_x(I_fine_x), .O_tile_index(O_tile_index), .O_bg_color(O_bg_color)
  );

  always #5 I_clock = ~I_clock;

  typedef struct {
    string      name;
    logic [3:0] color;
    logic [7:0] tile;
  } exp_t;

  exp_t       sb_q[$];
  int         tests    = 0;
  int         fails    = 0;
  logic       tb_chk   = 1'b0;
  logic       rst_chk  = 1'b0;
  logic [7:0] exp_tile = 8'h00;

  task automatic check_one();
    exp_t e;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL no_expected: output presented with empty scoreboard at %0t", $time);
    end else begin
      e = sb_q.pop_front();
      tests++;
      if (O_bg_color !== e.color) begin
        fails++;
        $display("FAIL %s bg_color: got %h expected %h at %0t", e.name, O_bg_color, e.color, $time);
      end
      tests++;
      if (O_tile_index !== e.tile) begin
        fails++;
        $display("FAIL %s tile_index: got %h expected %h at %0t", e.name, O_tile_index, e.tile, $time);
      end
    end
  endtask

  // Monitor: compare after each clock edge the stimulus flagged for checking
  always @(posedge I_clock) begin
    if (tb_chk) begin
      #1;
      check_one();
    end
  end

  // Monitor: compare just after an asynchronous reset assertion
  always @(negedge I_reset) begin
    if (rst_chk) begin
      #1;
      check_one();
    end
  end

  task automatic expect_out(input string nm, input logic [3:0] c);
    exp_t e;
    e.name  = nm;
    e.color = c;
    e.tile  = exp_tile;
    sb_q.push_back(e);
  endtask

  task automatic dot(input logic sh, input logic rl, input logic chk, input logic [3:0] c, input string nm);
    @(negedge I_clock);
    I_dot_clk  = 1'b1;
    I_shift_en = sh;
    I_reload   = rl;
    I_latch_we = 1'b0;
    tb_chk     = chk;
    if (chk) expect_out(nm, c);
    @(posedge I_clock);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] d);
    @(negedge I_clock);
    I_dot_clk   = 1'b1;
    I_shift_en  = 1'b0;
    I_reload    = 1'b0;
    I_latch_we  = 1'b1;
    I_latch_sel = sel;
    I_data      = d;
    tb_chk      = 1'b0;
    if (sel == 2'd0) exp_tile = d;
    @(posedge I_clock);
    #1;
  endtask

  task automatic idle();
    @(negedge I_clock);
    I_dot_clk  = 1'b0;
    I_shift_en = 1'b0;
    I_reload   = 1'b0;
    I_latch_we = 1'b0;
    tb_chk     = 1'b0;
    @(posedge I_clock);
    #1;
  endtask

  // Reload, eight shifts ending in shift+reload, then seven shifts; seq holds eight expected nibbles
  task automatic run_tile(input logic [31:0] seq, input string nm);
    dot(1'b0, 1'b1, 1'b0, 4'h0, "");
    for (int i = 0; i < 7; i++) dot(1'b1, 1'b0, 1'b0, 4'h0, "");
    dot(1'b1, 1'b1, 1'b1, seq[31:28], nm);
    for (int k = 1; k < 8; k++) dot(1'b1, 1'b0, 1'b1, seq[31-4*k -: 4], nm);
  endtask

  logic [63:0] sr_seq;
  logic [3:0]  hold_exp;
  logic [3:0]  live1_exp;
  logic [3:0]  live2_exp;

  initial begin
    sr_seq = 64'h5555_5554_8899_9988;
`ifdef VIDEO_BG_FINE_X_LATCH_EN
    hold_exp  = 4'h8;
    live1_exp = 4'hA;
    live2_exp = 4'h8;
`else
    hold_exp  = 4'hB;
    live1_exp = 4'h9;
    live2_exp = 4'hB;
`endif

    // Reset state observed while reset is held
    tb_chk = 1'b1;
    expect_out("reset_state", 4'h0);
    @(negedge I_clock);
    I_reset = 1'b1;
    tb_chk  = 1'b0;

    wr(2'd0, 8'h5A);

    // Attribute quadrant select: E4 = 11_10_01_00
    for (int q = 0; q < 4; q++) begin
      I_coarse_y1 = q[1];
      I_coarse_x1 = q[0];
      wr(2'd1, 8'hE4);
      dot(1'b0, 1'b1, 1'b0, 4'h0, "");
      for (int i = 0; i < 7; i++) dot(1'b1, 1'b0, 1'b0, 4'h0, "");
      dot(1'b1, 1'b0, 1'b1, 4'(q * 4), "attr_quadrant");
    end
    I_coarse_y1 = 1'b0;
    I_coarse_x1 = 1'b0;

    // Simultaneous shift+reload: pat_lo_sh FF00 + latch 3C -> FE3C, attribute takes the old bits
    wr(2'd1, 8'h01);
    wr(2'd2, 8'hFF);
    wr(2'd3, 8'h00);
    dot(1'b0, 1'b1, 1'b0, 4'h0, "");
    for (int i = 0; i < 8; i++) dot(1'b1, 1'b0, 1'b0, 4'h0, "");
    wr(2'd1, 8'h02);
    wr(2'd2, 8'h3C);
    dot(1'b1, 1'b1, 1'b1, sr_seq[63:60], "shift_reload");
    for (int k = 1; k < 16; k++) dot(1'b1, 1'b0, 1'b1, sr_seq[63-4*k -: 4], "shift_reload");

    // Tile pixels: pat_lo 0F, pat_hi 55, attr 10
    wr(2'd2, 8'h0F);
    wr(2'd3, 8'h55);
    wr(2'd1, 8'h02);
    I_fine_x = 3'd0;
    run_tile(32'h8A8A_9B9B, "tile_fine0");
    I_fine_x = 3'd3;
    run_tile(32'hA9B9_B8A8, "tile_fine3");

    // Dot gating: every strobe active but no dot enable for 10 cycles
    @(negedge I_clock);
    I_dot_clk   = 1'b0;
    I_shift_en  = 1'b1;
    I_reload    = 1'b1;
    I_latch_we  = 1'b1;
    I_latch_sel = 2'd0;
    I_data      = 8'hFF;
    I_fine_x    = 3'd0;
    tb_chk      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      expect_out("dot_gating", 4'h8);
      @(posedge I_clock);
      #1;
    end
    dot(1'b0, 1'b0, 1'b1, hold_exp, "gating_state");

    // Fine X change mid-tile
    I_fine_x = 3'd0;
    dot(1'b0, 1'b1, 1'b0, 4'h0, "");
    for (int i = 0; i < 7; i++) dot(1'b1, 1'b0, 1'b0, 4'h0, "");
    dot(1'b1, 1'b1, 1'b1, 4'h8, "fine_mid_tile");
    I_fine_x = 3'd5;
    dot(1'b1, 1'b0, 1'b1, live1_exp, "fine_mid_tile");
    dot(1'b1, 1'b0, 1'b1, live2_exp, "fine_mid_tile");
    for (int i = 0; i < 5; i++) dot(1'b1, 1'b0, 1'b0, 4'h0, "");
    dot(1'b1, 1'b1, 1'b0, 4'h0, "");
    dot(1'b1, 1'b0, 1'b1, 4'h9, "fine_after_reload");
    dot(1'b1, 1'b0, 1'b1, 4'hB, "fine_after_reload");
    idle();

    // Asynchronous reset mid-stream with loaded shifters
    rst_chk  = 1'b1;
    exp_tile = 8'h00;
    expect_out("reset_async", 4'h0);
    @(negedge I_clock);
    #2;
    I_reset = 1'b0;
    @(posedge I_clock);
    #2;
    rst_chk = 1'b0;
    @(negedge I_clock);
    tb_chk = 1'b1;
    expect_out("reset_hold", 4'h0);
    @(posedge I_clock);
    #1;
    @(negedge I_clock);
    I_reset = 1'b1;
    expect_out("reset_release", 4'h0);
    @(posedge I_clock);
    #1;
    dot(1'b0, 1'b0, 1'b1, 4'h0, "first_dot_after_reset");
    idle();

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge I_clock);
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected entries never checked, required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
